// File: rtl/anim_pkg.sv
// Shared definitions for the tile-slide animation timer and the render block.
// Holds the FSM state encoding and the default animation timing constants.
package anim_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int DEF_STEP_DIV    = 4;
  localparam int DEF_NUM_STEPS   = 8;
  localparam int DEF_STEP_W      = 3;
  localparam int DEF_WDOG_CYCLES = 16;

endpackage

// File: rtl/anim_step_timer_watchdog.sv
// Strobe watchdog: counts clocks since the last stb and flags a fault once
// the count saturates at WDOG_CYCLES.
module stb_watchdog #(
  parameter int WDOG_CYCLES = anim_pkg::DEF_WDOG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  output logic stb_fault
);

  localparam int CNT_W = $clog2(WDOG_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] wdogCnt_q, wdogCnt_d;
  logic             fault_q;

  // Saturate rather than wrap so the fault stays up for as long as stb is missing.
  always_comb begin
    wdogCnt_d = wdogCnt_q;
    if (stb) begin
      wdogCnt_d = '0;
    end else if (wdogCnt_q != CNT_MAX) begin
      wdogCnt_d = wdogCnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdogCnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      wdogCnt_q <= wdogCnt_d;
      fault_q   <= (wdogCnt_d == CNT_MAX);
    end
  end

  assign stb_fault = fault_q;

endmodule

// File: rtl/anim_step_timer.sv
// Tile-slide animation timer: runs NUM_STEPS steps of STEP_DIV strobes each
// on a start request, with abort, per-step tick, done pulse and strobe watchdog.
module anim_step_timer
  import anim_pkg::*;
#(
  parameter int STEP_DIV    = DEF_STEP_DIV,
  parameter int NUM_STEPS   = DEF_NUM_STEPS,
  parameter int STEP_W      = DEF_STEP_W,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic              CLK100MHZ,
  input  logic              rst,
  input  logic              stb,
  input  logic              start,
  input  logic              abort,
  output logic [STEP_W-1:0] step,
  output logic              step_tick,
  output logic              busy,
  output logic              done,
  output logic              stb_fault
);

  localparam int DIV_W = $clog2(STEP_DIV) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(NUM_STEPS - 1);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

  state_t            state_q;
  logic [DIV_W-1:0]  divCnt_q;
  logic [STEP_W-1:0] step_q;
  logic              stepTick_q;
  logic              busy_q;
  logic              done_q;

  // The stb that arrives with an accepted start is ignored because IDLE never
  // counts; abort takes priority over any boundary landing in the same cycle.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state_q    <= S_IDLE;
      divCnt_q   <= '0;
      step_q     <= '0;
      stepTick_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      stepTick_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            step_q   <= '0;
            divCnt_q <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            step_q   <= '0;
            divCnt_q <= '0;
          end else if (stb) begin
            if (divCnt_q == DIV_LAST) begin
              divCnt_q   <= '0;
              stepTick_q <= 1'b1;
              if (step_q == STEP_LAST) begin
                step_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                step_q <= step_q + STEP_ONE;
              end
            end else begin
              divCnt_q <= divCnt_q + DIV_ONE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  stb_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) uWatchdog (
    .clk      (CLK100MHZ),
    .rst      (rst),
    .stb      (stb),
    .stb_fault(stb_fault)
  );

  assign step      = step_q;
  assign step_tick = stepTick_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_anim_step_timer.sv
// Self-checking bench for anim_step_timer: directed scenarios plus a random
// phase, compared every cycle against a counted-strobe reference model.
module tb_anim_step_timer;

  localparam int STEP_DIV    = 4;
  localparam int NUM_STEPS   = 8;
  localparam int STEP_W      = 3;
  localparam int WDOG_CYCLES = 16;

  logic              clock;
  logic              reset;
  logic              stb;
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] step;
  logic              stepTick;
  logic              busy;
  logic              done;
  logic              stbFault;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state: strobes counted in the current run, run flag,
  // and clocks since the last strobe.
  int mCounted = 0;
  bit mBusy    = 0;
  int mNoStb   = 0;
  int expStep  = 0;
  bit expTick  = 0;
  bit expBusy  = 0;
  bit expDone  = 0;
  bit expFault = 0;

  int dutDoneCount   = 0;
  int modelDoneCount = 0;

  bit stbEnable = 1;
  bit randomStb = 0;
  int stbPhase  = 0;

  anim_step_timer #(
    .STEP_DIV   (STEP_DIV),
    .NUM_STEPS  (NUM_STEPS),
    .STEP_W     (STEP_W),
    .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .CLK100MHZ(clock),
    .rst      (reset),
    .stb      (stb),
    .start    (start),
    .abort    (abort),
    .step     (step),
    .step_tick(stepTick),
    .busy     (busy),
    .done     (done),
    .stb_fault(stbFault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance the reference model by one clock using the inputs sampled at that edge.
  task automatic modelUpdate(input bit stbV, input bit startV, input bit abortV, input bit rstV);
    expTick = 0;
    expDone = 0;
    if (rstV) begin
      mBusy    = 0;
      mCounted = 0;
      mNoStb   = 0;
    end else begin
      if (!mBusy) begin
        if (startV && !abortV) begin
          mBusy    = 1;
          mCounted = 0;
        end
      end else if (abortV) begin
        mBusy    = 0;
        mCounted = 0;
      end else if (stbV) begin
        mCounted++;
        if (mCounted % STEP_DIV == 0) expTick = 1;
        if (mCounted == NUM_STEPS * STEP_DIV) begin
          expDone  = 1;
          mBusy    = 0;
          mCounted = 0;
          modelDoneCount++;
        end
      end
      if (stbV) mNoStb = 0;
      else if (mNoStb < WDOG_CYCLES) mNoStb++;
    end
    expBusy  = mBusy;
    expStep  = mCounted / STEP_DIV;
    expFault = (mNoStb >= WDOG_CYCLES);
  endtask

  task automatic checkOutput();
    testsRun++;
    assert (step === STEP_W'(expStep)) else begin
      testsFailed++;
      $error("[TB] FAIL step: observed %0d expected %0d at %0t", step, expStep, $time);
    end
    testsRun++;
    assert (stepTick === expTick) else begin
      testsFailed++;
      $error("[TB] FAIL step_tick: observed %0b expected %0b at %0t", stepTick, expTick, $time);
    end
    testsRun++;
    assert (busy === expBusy) else begin
      testsFailed++;
      $error("[TB] FAIL busy: observed %0b expected %0b at %0t", busy, expBusy, $time);
    end
    testsRun++;
    assert (done === expDone) else begin
      testsFailed++;
      $error("[TB] FAIL done: observed %0b expected %0b at %0t", done, expDone, $time);
    end
    testsRun++;
    assert (stbFault === expFault) else begin
      testsFailed++;
      $error("[TB] FAIL stb_fault: observed %0b expected %0b at %0t", stbFault, expFault, $time);
    end
    if (done === 1'b1) dutDoneCount++;
  endtask

  task automatic applyStimulus(input bit stbV, input bit startV, input bit abortV, input bit rstV);
    stb   = stbV;
    start = startV;
    abort = abortV;
    reset = rstV;
    @(posedge clock);
    #1;
    modelUpdate(stbV, startV, abortV, rstV);
    checkOutput();
  endtask

  // One clock with the bench's strobe source (periodic every 4 clocks, or random).
  task automatic tickCycle(input bit startV, input bit abortV, input bit rstV);
    bit stbV;
    stbV     = stbEnable && (stbPhase == 3);
    stbPhase = (stbPhase + 1) % 4;
    if (randomStb) stbV = stbEnable && ($urandom_range(0, 2) == 0);
    applyStimulus(stbV, startV, abortV, rstV);
  endtask

  task automatic runCycles(input int n, input bit startV);
    for (int i = 0; i < n; i++) tickCycle(startV, 1'b0, 1'b0);
  endtask

  task automatic runUntilStep(input int target, input int budget);
    int n;
    n = 0;
    while (expStep != target && n < budget) begin
      tickCycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    testsRun++;
    assert (n < budget) else begin
      testsFailed++;
      $error("[TB] FAIL reach_step%0d: observed timeout after %0d expected < %0d cycles", target, n, budget);
    end
  endtask

  task automatic runUntilDone(input bit startV, input int budget);
    int n;
    n = 0;
    do begin
      tickCycle(startV, 1'b0, 1'b0);
      n++;
    end while (!expDone && n < budget);
    testsRun++;
    assert (expDone) else begin
      testsFailed++;
      $error("[TB] FAIL reach_done: observed timeout after %0d expected < %0d cycles", n, budget);
    end
  endtask

  initial begin
    stb   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;

    // Reset, then a one-cycle reset in the middle of a running animation.
    tickCycle(1'b0, 1'b0, 1'b1);
    tickCycle(1'b0, 1'b0, 1'b1);
    runCycles(5, 1'b0);
    tickCycle(1'b1, 1'b0, 1'b0);
    runCycles(20, 1'b0);
    tickCycle(1'b0, 1'b0, 1'b1);
    runCycles(6, 1'b0);

    // Full run from a start pulse; exactly one done pulse expected.
    dutDoneCount   = 0;
    modelDoneCount = 0;
    tickCycle(1'b1, 1'b0, 1'b0);
    runUntilDone(1'b0, 200);
    runCycles(4, 1'b0);
    testsRun++;
    assert (dutDoneCount === 1) else begin
      testsFailed++;
      $error("[TB] FAIL done_count: observed %0d expected 1", dutDoneCount);
    end

    // Abort at step 3, then start and abort together while idle.
    tickCycle(1'b1, 1'b0, 1'b0);
    runUntilStep(3, 100);
    runCycles(2, 1'b0);
    tickCycle(1'b0, 1'b1, 1'b0);
    runCycles(8, 1'b0);
    tickCycle(1'b1, 1'b1, 1'b0);
    runCycles(8, 1'b0);

    // Re-start at step 5 is ignored; then start held high through done.
    tickCycle(1'b1, 1'b0, 1'b0);
    runUntilStep(5, 150);
    tickCycle(1'b1, 1'b0, 1'b0);
    runUntilDone(1'b0, 200);
    tickCycle(1'b1, 1'b0, 1'b0);
    runUntilDone(1'b1, 200);
    runCycles(3, 1'b1);
    tickCycle(1'b0, 1'b1, 1'b0);
    runCycles(4, 1'b0);

    // Start accepted in the same cycle as a strobe: that strobe is not counted.
    while (stbPhase != 3) tickCycle(1'b0, 1'b0, 1'b0);
    tickCycle(1'b1, 1'b0, 1'b0);
    runUntilStep(2, 100);

    // Strobe loss for 20 clocks freezes the run and raises the fault.
    stbEnable = 0;
    runCycles(20, 1'b0);
    stbEnable = 1;
    runUntilDone(1'b0, 200);
    runCycles(4, 1'b0);

    // Random strobes, starts, aborts, resets and strobe outages.
    randomStb = 1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) stbEnable = 0;
      if (!stbEnable && $urandom_range(0, 24) == 0) stbEnable = 1;
      tickCycle($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 399) == 0);
    end
    stbEnable = 1;
    randomStb = 0;
    runCycles(8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
